// File: rtl/pll_cfg_pkg.sv
// Shared states, register map constants and the queued-command record for pll_cfg_seq.
// No logic; latency and backpressure are defined by the users of these types.
package pll_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MODE,
      WRITE,
      START,
      LOCKWAIT,
      DONE,
      ERR
   } state_t;

   localparam logic [5:0]  REG_MODE     = 6'h00;
   localparam logic [5:0]  REG_START    = 6'h02;
   localparam logic [31:0] MODE_WAITREQ = 32'h0000_0000;
   localparam logic [31:0] START_VAL    = 32'h0000_0001;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } cmd_t;

endpackage

// File: rtl/pll_cfg_fifo.sv
// First-word-fall-through command queue; the head is visible the cycle after the push.
// Pushes while full and pops while empty are dropped; the parent gates them anyway.
module pll_cfg_fifo
   import pll_cfg_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  cmd_t i_dat,
   input  logic i_pop,
   input  logic i_flush,
   output logic o_full,
   output logic o_empty,
   output logic o_last,
   output cmd_t o_head
);

   localparam int AW = $clog2(DEPTH);

   cmd_t           r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_push;
   logic           w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_last  = (r_count == (AW+1)'(1));
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfig sequencer: mode write, queued writes, start, relock wait; bus write 1 clk after go.
// Each Avalon transfer holds while mgmt_waitrequest=1; cmd_ready drops when full or not IDLE.
module pll_cfg_seq
   import pll_cfg_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int LOCK_STABLE  = 64,
   parameter int LOCK_TIMEOUT = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   input  logic        go,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked
);

   localparam int SW = $clog2(LOCK_STABLE + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_lock_s1;
   logic            r_lock_s2;
   logic [SW-1:0]   r_stable;
   logic [SW-1:0]   w_stable_nxt;
   logic [TW-1:0]   r_tmo;
   logic [TW-1:0]   w_tmo_nxt;
   logic            r_write;
   logic            w_write_nxt;
   logic            w_push;
   logic            w_pop;
   logic            w_xfer;
   logic            w_full;
   logic            w_empty;
   logic            w_last;
   cmd_t            w_cmd;
   cmd_t            w_head;

   assign cmd_ready  = !w_full && (r_state == IDLE);
   assign w_push     = cmd_valid && cmd_ready;
   assign w_cmd      = '{addr: cmd_addr, data: cmd_data};
   assign w_xfer     = r_write && !mgmt_waitrequest;
   assign w_pop      = (r_state == WRITE) && w_xfer;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign timeout    = (r_state == ERR);
   assign mgmt_write = r_write;

   pll_cfg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_dat   (w_cmd),
      .i_pop   (w_pop),
      .i_flush (r_state == ERR),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_last  (w_last),
      .o_head  (w_head)
   );

   // On a same-cycle stable/timeout hit the success branch is checked first.
   always_comb begin
      w_state_nxt  = r_state;
      w_stable_nxt = r_lock_s2 ? r_stable + 1'b1 : '0;
      w_tmo_nxt    = r_tmo + 1'b1;
      case (r_state)
         IDLE: begin
            if (go) begin
               w_state_nxt = (!w_empty || w_push) ? MODE : DONE;
            end
         end
         MODE: begin
            if (w_xfer) begin
               w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (w_xfer && w_last) begin
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_xfer) begin
               w_state_nxt = LOCKWAIT;
            end
         end
         LOCKWAIT: begin
            if (w_stable_nxt == SW'(LOCK_STABLE)) begin
               w_state_nxt = DONE;
            end else if (w_tmo_nxt == TW'(LOCK_TIMEOUT)) begin
               w_state_nxt = ERR;
            end
         end
         DONE:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      w_write_nxt = (w_state_nxt == MODE) || (w_state_nxt == WRITE) || (w_state_nxt == START);
   end

   // Address/data follow registered state and the FIFO head, both frozen during a stall.
   always_comb begin
      mgmt_address   = '0;
      mgmt_writedata = '0;
      case (r_state)
         MODE: begin
            mgmt_address   = REG_MODE;
            mgmt_writedata = MODE_WAITREQ;
         end
         WRITE: begin
            mgmt_address   = w_head.addr;
            mgmt_writedata = w_head.data;
         end
         START: begin
            mgmt_address   = REG_START;
            mgmt_writedata = START_VAL;
         end
         default: begin
            mgmt_address   = '0;
            mgmt_writedata = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
         r_stable  <= '0;
         r_tmo     <= '0;
         r_write   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_s1 <= pll_locked;
         r_lock_s2 <= r_lock_s1;
         r_write   <= w_write_nxt;
         if (r_state == LOCKWAIT) begin
            r_stable <= w_stable_nxt;
            r_tmo    <= w_tmo_nxt;
         end else begin
            r_stable <= '0;
            r_tmo    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq: bus trace tables plus stall, glitch, timeout, full and reset cases.
// A second instance with a short lock timeout covers the error path.
module tb_pll_cfg_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [5:0]  cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        go = 1'b0;
   logic        wreq = 1'b0;
   logic        locked = 1'b0;
   logic        cmd_ready, busy, done, timeout, mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;

   logic        t_cmd_valid = 1'b0;
   logic        t_go = 1'b0;
   logic        t_cmd_ready, t_busy, t_done, t_timeout, t_mgmt_write;
   logic [5:0]  t_mgmt_address;
   logic [31:0] t_mgmt_writedata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pll_cfg_seq #(.DEPTH(16), .LOCK_STABLE(64), .LOCK_TIMEOUT(1048576)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .go(go), .busy(busy), .done(done),
      .timeout(timeout), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
      .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(wreq), .pll_locked(locked)
   );

   pll_cfg_seq #(.DEPTH(16), .LOCK_STABLE(64), .LOCK_TIMEOUT(100)) dut_tmo (
      .clk(clk), .reset(reset), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
      .cmd_addr(6'h04), .cmd_data(32'h0000_0808), .go(t_go), .busy(t_busy), .done(t_done),
      .timeout(t_timeout), .mgmt_address(t_mgmt_address), .mgmt_write(t_mgmt_write),
      .mgmt_writedata(t_mgmt_writedata), .mgmt_waitrequest(1'b0), .pll_locked(1'b0)
   );

   typedef struct {
      logic        wr;
      logic [5:0]  a;
      logic [31:0] d;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic chk_bus(input string name, input vec_t v);
      chk({name, "_write"}, {31'd0, mgmt_write}, {31'd0, v.wr});
      chk({name, "_addr"}, {26'd0, mgmt_address}, {26'd0, v.a});
      chk({name, "_data"}, mgmt_writedata, v.d);
   endtask

   task automatic wait_done(input string name, input int exp_n);
      int n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      chk(name, n, exp_n);
   endtask

   task automatic wait_bus_idle(input string name);
      int n = 0;
      while (mgmt_write && n < 100) begin
         tick();
         n++;
      end
      chk(name, {31'd0, mgmt_write}, 32'd0);
   endtask

   initial begin
      vec_t basic[5];
      vec_t stall[4];
      int   n;
      bit   seen;

      basic[0] = '{1'b1, 6'h00, 32'h0000_0000};
      basic[1] = '{1'b1, 6'h04, 32'h0000_0808};
      basic[2] = '{1'b1, 6'h03, 32'h0001_0000};
      basic[3] = '{1'b1, 6'h02, 32'h0000_0001};
      basic[4] = '{1'b0, 6'h00, 32'h0000_0000};
      stall[0] = '{1'b1, 6'h00, 32'h0000_0000};
      stall[1] = '{1'b1, 6'h05, 32'hA5A5_0001};
      stall[2] = '{1'b1, 6'h05, 32'h5A5A_0002};
      stall[3] = '{1'b1, 6'h02, 32'h0000_0001};

      tick();
      tick();
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk_bus("rst", basic[4]);
      reset = 1'b0;
      tick();

      // lock never arrives on the short-timeout instance
      t_cmd_valid = 1'b1;
      tick();
      t_cmd_valid = 1'b0;
      t_go = 1'b1;
      tick();
      t_go = 1'b0;
      n = 0;
      while (t_mgmt_write && n < 20) begin
         tick();
         n++;
      end
      chk("tmo_bus_cycles", n, 3);
      n = 0;
      seen = 0;
      while (!t_timeout && n < 300) begin
         tick();
         n++;
         if (t_done) seen = 1;
      end
      chk("tmo_latency", n, 100);
      chk("tmo_no_done", {31'd0, seen}, 32'd0);
      tick();
      chk("tmo_pulse_width", {31'd0, t_timeout}, 32'd0);
      chk("tmo_busy_after", {31'd0, t_busy}, 32'd0);
      chk("tmo_ready_after", {31'd0, t_cmd_ready}, 32'd1);

      // basic sequence, back-to-back bus cycles
      push(6'h04, 32'h0000_0808);
      push(6'h03, 32'h0001_0000);
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_bus($sformatf("basic%0d", i), basic[i]);
         tick();
      end
      repeat (9) tick();
      locked = 1'b1;
      wait_done("basic_done_latency", 66);
      tick();
      chk("basic_done_width", {31'd0, done}, 32'd0);
      chk("basic_busy_after", {31'd0, busy}, 32'd0);
      locked = 1'b0;
      repeat (4) tick();

      // 5-cycle stall on every transfer, duplicate addresses kept
      push(6'h05, 32'hA5A5_0001);
      push(6'h05, 32'h5A5A_0002);
      go = 1'b1;
      tick();
      go = 1'b0;
      for (int t = 0; t < 4; t++) begin
         wreq = 1'b1;
         for (int k = 0; k < 5; k++) begin
            chk_bus($sformatf("stall%0d_%0d", t, k), stall[t]);
            tick();
         end
         chk_bus($sformatf("stall%0d_rel", t), stall[t]);
         wreq = 1'b0;
         tick();
      end
      chk("stall_write_end", {31'd0, mgmt_write}, 32'd0);
      locked = 1'b1;
      wait_done("stall_done_latency", 66);
      tick();
      locked = 1'b0;
      repeat (4) tick();

      // lock glitch restarts the stable count
      push(6'h06, 32'h0000_1234);
      go = 1'b1;
      tick();
      go = 1'b0;
      wait_bus_idle("glitch_bus_idle");
      locked = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (done) seen = 1;
      end
      locked = 1'b0;
      tick();
      if (done) seen = 1;
      locked = 1'b1;
      wait_done("glitch_done_latency", 66);
      chk("glitch_no_early_done", {31'd0, seen}, 32'd0);
      tick();
      locked = 1'b0;
      repeat (4) tick();

      // go with an empty queue
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("empty_done", {31'd0, done}, 32'd1);
      chk("empty_write", {31'd0, mgmt_write}, 32'd0);
      tick();
      chk("empty_done_width", {31'd0, done}, 32'd0);
      chk("empty_busy_after", {31'd0, busy}, 32'd0);
      chk("empty_write_after", {31'd0, mgmt_write}, 32'd0);

      // fill to capacity, reject the 17th, go while busy
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("full_ready%0d", i), {31'd0, cmd_ready}, 32'd1);
         push(6'(i + 8), 32'hC0DE_0000 + 32'(i));
      end
      chk("full_ready_low", {31'd0, cmd_ready}, 32'd0);
      push(6'h3F, 32'hDEAD_BEEF);
      go = 1'b1;
      tick();
      go = 1'b0;
      chk_bus("full_mode", basic[0]);
      tick();
      for (int i = 0; i < 16; i++) begin
         vec_t v;
         v = '{1'b1, 6'(i + 8), 32'hC0DE_0000 + 32'(i)};
         chk_bus($sformatf("full_w%0d", i), v);
         if (i == 5) go = 1'b1;
         tick();
         go = 1'b0;
      end
      chk_bus("full_start", basic[3]);
      tick();
      chk("full_write_end", {31'd0, mgmt_write}, 32'd0);
      locked = 1'b1;
      wait_done("full_done_latency", 66);
      tick();
      locked = 1'b0;
      repeat (4) tick();
      chk("busy_go_ignored", {31'd0, busy}, 32'd0);
      chk("busy_go_no_write", {31'd0, mgmt_write}, 32'd0);

      // reset in the middle of the write burst
      push(6'h01, 32'h11);
      push(6'h02, 32'h22);
      push(6'h03, 32'h33);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      tick();
      chk("rstmid_pre_addr", {26'd0, mgmt_address}, 32'h02);
      reset = 1'b1;
      tick();
      chk("rstmid_write", {31'd0, mgmt_write}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
      reset = 1'b0;
      tick();
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("rstmid_go_done", {31'd0, done}, 32'd1);
      chk("rstmid_go_write", {31'd0, mgmt_write}, 32'd0);
      tick();
      chk("rstmid_idle_write", {31'd0, mgmt_write}, 32'd0);
      chk("rstmid_idle_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
